// File: rtl/fpu_pkg.sv
// Shared types and constants for the binary32 add/sub datapath.
package fpu_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;
  // Working significand: hidden bit + fraction + guard/round/sticky.
  localparam int SIG_W  = FRAC_W + 4;

  localparam logic [31:0] QNAN    = 32'h7fc00000;
  localparam logic [31:0] POS_INF = 32'h7f800000;

  typedef enum logic [2:0] {
    S_WAIT, S_UNPACK, S_ALIGN, S_ADD, S_NORMALIZE, S_ROUND, S_DONE
  } state_t;

  typedef enum logic [2:0] {
    C_ZERO, C_SUB, C_NORM, C_INF, C_NAN
  } op_class_t;

  function automatic op_class_t classify(input logic [31:0] x);
    if (x[30:23] == 8'hff) return (x[22:0] != '0) ? C_NAN : C_INF;
    if (x[30:23] == 8'h00) return (x[22:0] != '0) ? C_SUB : C_ZERO;
    return C_NORM;
  endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Leading-zero counter over the working significand (27 bits -> 0..27).
import fpu_pkg::*;

module fpu_lzc (
  input  logic [SIG_W-1:0] sig,
  output logic [4:0]       count
);

  // Scan upward so the highest set bit determines the final count.
  always_comb begin
    count = 5'(SIG_W);
    for (int i = 0; i < SIG_W; i++)
      if (sig[i]) count = 5'(SIG_W - 1 - i);
  end

endmodule

// File: rtl/fpu_add_rtl.sv
// Multi-cycle binary32 adder, round-to-nearest-even, fixed latency.
// One FSM state per datapath stage; specials are resolved in UNPACK and
// ride through the pipeline so latency never depends on the operands.
import fpu_pkg::*;

module fpu_add_rtl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] din1,
  input  logic [31:0] din2,
  input  logic        valid,
  output logic [31:0] result,
  output logic        ready
);

  state_t state, state_nxt;
  logic   ld_in, do_unpack, do_align, do_add, do_norm, do_round, do_done;

  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_WAIT;
    else       state <= state_nxt;

  // next-state: fixed walk through the stages, valid only matters in WAIT
  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT:      if (valid) state_nxt = S_UNPACK;
      S_UNPACK:    state_nxt = S_ALIGN;
      S_ALIGN:     state_nxt = S_ADD;
      S_ADD:       state_nxt = S_NORMALIZE;
      S_NORMALIZE: state_nxt = S_ROUND;
      S_ROUND:     state_nxt = S_DONE;
      S_DONE:      state_nxt = S_WAIT;
      default:     state_nxt = S_WAIT;
    endcase
  end

  // per-stage load strobes decoded from the state
  always_comb begin
    ld_in     = (state == S_WAIT) && valid;
    do_unpack = (state == S_UNPACK);
    do_align  = (state == S_ALIGN);
    do_add    = (state == S_ADD);
    do_norm   = (state == S_NORMALIZE);
    do_round  = (state == S_ROUND);
    do_done   = (state == S_DONE);
  end

  // ---------------- operand capture
  logic [31:0] a_q, b_q;

  // latch operands on an accepted start
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
    end else if (ld_in) begin
      a_q <= din1;
      b_q <= din2;
    end

  // ---------------- UNPACK
  op_class_t   ca, cb;
  logic        special_d;
  logic [31:0] spec_val_d;

  // special-case resolution; priority: NaN, inf, zero
  always_comb begin
    ca         = classify(a_q);
    cb         = classify(b_q);
    special_d  = 1'b1;
    spec_val_d = '0;
    if (ca == C_NAN || cb == C_NAN)      spec_val_d = QNAN;
    else if (ca == C_INF && cb == C_INF) spec_val_d = (a_q[31] ^ b_q[31]) ? QNAN : a_q;
    else if (ca == C_INF)                spec_val_d = a_q;
    else if (cb == C_INF)                spec_val_d = b_q;
    else if (ca == C_ZERO && cb == C_ZERO)
      spec_val_d = {a_q[31] & b_q[31], 31'b0};
    else if (ca == C_ZERO)               spec_val_d = b_q;
    else if (cb == C_ZERO)               spec_val_d = a_q;
    else                                 special_d  = 1'b0;
  end

  logic              special_q, sa_q, sb_q;
  logic [31:0]       spec_val_q;
  logic [EXP_W-1:0]  ea_q, eb_q;
  logic [FRAC_W:0]   ma_q, mb_q;

  // split fields; subnormals get hidden bit 0 and effective exponent 1
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      special_q <= 1'b0; spec_val_q <= '0;
      sa_q <= 1'b0; sb_q <= 1'b0;
      ea_q <= '0;   eb_q <= '0;
      ma_q <= '0;   mb_q <= '0;
    end else if (do_unpack) begin
      special_q  <= special_d;
      spec_val_q <= spec_val_d;
      sa_q <= a_q[31];
      sb_q <= b_q[31];
      ea_q <= (a_q[30:23] == '0) ? 8'd1 : a_q[30:23];
      eb_q <= (b_q[30:23] == '0) ? 8'd1 : b_q[30:23];
      ma_q <= {|a_q[30:23], a_q[22:0]};
      mb_q <= {|b_q[30:23], b_q[22:0]};
    end

  // ---------------- ALIGN
  logic              a_ge;
  logic [EXP_W-1:0]  el, es, dexp;
  logic [FRAC_W:0]   ml, ms;
  logic [2*SIG_W-1:0] wide;
  logic [SIG_W-1:0]  small_d;

  // order by magnitude and shift the smaller significand, folding lost bits into sticky
  always_comb begin
    a_ge = {ea_q, ma_q} >= {eb_q, mb_q};
    el   = a_ge ? ea_q : eb_q;
    es   = a_ge ? eb_q : ea_q;
    ml   = a_ge ? ma_q : mb_q;
    ms   = a_ge ? mb_q : ma_q;
    dexp = el - es;
    wide = {ms, 3'b000, {SIG_W{1'b0}}} >> dexp;
    if (dexp >= 8'd27) small_d = {{(SIG_W-1){1'b0}}, |ms};
    else               small_d = {wide[2*SIG_W-1:SIG_W+1], wide[SIG_W] | (|wide[SIG_W-1:0])};
  end

  logic             sign_q, sub_q;
  logic [8:0]       exp_q;
  logic [SIG_W-1:0] big_q, small_q;

  // aligned operands and result sign
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sign_q <= 1'b0; sub_q <= 1'b0; exp_q <= '0;
      big_q  <= '0;   small_q <= '0;
    end else if (do_align) begin
      sign_q  <= a_ge ? sa_q : sb_q;
      sub_q   <= sa_q ^ sb_q;
      exp_q   <= {1'b0, el};
      big_q   <= {ml, 3'b000};
      small_q <= small_d;
    end

  // ---------------- ADD
  logic [SIG_W:0] sum_q;

  // magnitude add or subtract; big >= small so no borrow out
  always_ff @(posedge clk or posedge reset)
    if (reset)       sum_q <= '0;
    else if (do_add) sum_q <= sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                                    : ({1'b0, big_q} + {1'b0, small_q});

  // ---------------- NORMALIZE
  logic [4:0]       lz;
  logic [8:0]       lim, sh, nexp_d;
  logic [SIG_W-1:0] norm_d;
  logic             zero_d;

  fpu_lzc u_lzc (.sig(sum_q[SIG_W-1:0]), .count(lz));

  // carry -> shift right one; else shift left by lzc, clamped at exponent 1
  always_comb begin
    lim    = exp_q - 9'd1;
    sh     = ({4'b0, lz} > lim) ? lim : {4'b0, lz};
    zero_d = 1'b0;
    if (sum_q[SIG_W]) begin
      norm_d = {sum_q[SIG_W:2], sum_q[1] | sum_q[0]};
      nexp_d = exp_q + 9'd1;
    end else begin
      norm_d = sum_q[SIG_W-1:0] << sh;
      nexp_d = exp_q - sh;
      zero_d = (sum_q == '0);
    end
  end

  logic [SIG_W-1:0] norm_q;
  logic [8:0]       nexp_q;
  logic             zero_q;

  // normalized significand and exponent
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      norm_q <= '0; nexp_q <= '0; zero_q <= 1'b0;
    end else if (do_norm) begin
      norm_q <= norm_d;
      nexp_q <= nexp_d;
      zero_q <= zero_d;
    end

  // ---------------- ROUND
  logic          inc;
  logic [FRAC_W+1:0] rnd;
  logic [FRAC_W:0]   mant;
  logic [8:0]    rexp;
  logic [31:0]   res_d;

  // nearest-even, then pack; a leading 0 after rounding encodes a subnormal
  always_comb begin
    inc = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
    rnd = {1'b0, norm_q[SIG_W-1:3]} + {{(FRAC_W+1){1'b0}}, inc};
    if (rnd[FRAC_W+1]) begin
      mant = rnd[FRAC_W+1:1];
      rexp = nexp_q + 9'd1;
    end else begin
      mant = rnd[FRAC_W:0];
      rexp = nexp_q;
    end
    if (special_q)          res_d = spec_val_q;
    else if (zero_q)        res_d = '0;
    else if (rexp >= 9'd255) res_d = {sign_q, 31'b0} | POS_INF;
    else res_d = {sign_q, mant[FRAC_W] ? rexp[7:0] : 8'h00, mant[FRAC_W-1:0]};
  end

  logic [31:0] res_q;

  // rounded result staged for DONE
  always_ff @(posedge clk or posedge reset)
    if (reset)         res_q <= '0;
    else if (do_round) res_q <= res_d;

  // ---------------- outputs
  // registered outputs: one ready pulse per operation, result held in between
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      result <= '0;
      ready  <= 1'b0;
    end else begin
      ready <= do_done;
      if (do_done) result <= res_q;
    end

endmodule

// File: tb/tb_fpu_add_rtl.sv
// Self-checking bench for fpu_add_rtl: vector table + scoreboard queue.
module tb_fpu_add_rtl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] din1, din2;
  logic        valid;
  logic [31:0] result;
  logic        ready;

  fpu_add_rtl dut (
    .clk(clk), .reset(reset), .din1(din1), .din2(din2),
    .valid(valid), .result(result), .ready(ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } vec_t;

  vec_t        vecs[17];
  logic [31:0] exp_q[$];
  int          id_q[$];
  int          compared   = 0;
  int          mismatched = 0;
  int          ready_cnt  = 0;

  // scoreboard: every ready pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (ready) begin
      ready_cnt++;
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_ready result=%h (no operation outstanding)", result);
      end else begin
        logic [31:0] e;
        int          id;
        e  = exp_q.pop_front();
        id = id_q.pop_front();
        if (result !== e) begin
          mismatched++;
          $display("FAIL vec%0d result got=%h want=%h", id, result, e);
        end
      end
    end
  end

  // start one op, check latency (7 negedges after the drive) and result hold
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e, input int id);
    int          lat;
    logic [31:0] held;
    @(negedge clk);
    din1 = a; din2 = b; valid = 1'b1;
    exp_q.push_back(e); id_q.push_back(id);
    @(negedge clk);
    valid = 1'b0; din1 = $urandom; din2 = $urandom;
    lat = 1;
    while (!ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    compared++;
    if (!ready) begin
      mismatched++;
      $display("FAIL vec%0d timeout waiting for ready", id);
      void'(exp_q.pop_back()); void'(id_q.pop_back());
      return;
    end
    if (lat != 7) begin
      mismatched++;
      $display("FAIL vec%0d latency got=%0d want=7", id, lat);
    end
    held = result;
    @(negedge clk);
    compared++;
    if (ready || result !== held) begin
      mismatched++;
      $display("FAIL vec%0d hold ready=%b result=%h want ready=0 result=%h", id, ready, result, held);
    end
  endtask

  initial begin
    int base;
    vecs[0]  = '{32'h3f800000, 32'h3f800000, 32'h40000000};
    vecs[1]  = '{32'h40000000, 32'h40400000, 32'h40a00000};
    vecs[2]  = '{32'h7f800000, 32'h3f800000, 32'h7f800000};
    vecs[3]  = '{32'h7f800000, 32'hff800000, 32'h7fc00000};
    vecs[4]  = '{32'h7fc00000, 32'h00000000, 32'h7fc00000};
    vecs[5]  = '{32'h7f800001, 32'h3f800000, 32'h7fc00000};
    vecs[6]  = '{32'h80000000, 32'h80000000, 32'h80000000};
    vecs[7]  = '{32'hc0000000, 32'h40000000, 32'h00000000};
    vecs[8]  = '{32'h3f800000, 32'hb3800000, 32'h3f7fffff};
    vecs[9]  = '{32'h00000001, 32'h00000001, 32'h00000002};
    vecs[10] = '{32'h3f800000, 32'h33800000, 32'h3f800000};
    vecs[11] = '{32'h3f800001, 32'h33800000, 32'h3f800002};
    vecs[12] = '{32'h7f7fffff, 32'h7f7fffff, 32'h7f800000};
    vecs[13] = '{32'h00000000, 32'h80000000, 32'h00000000};
    vecs[14] = '{32'h00000000, 32'hc0490fdb, 32'hc0490fdb};
    vecs[15] = '{32'h3fc00000, 32'hbf800000, 32'h3f000000};
    vecs[16] = '{32'h00800000, 32'h80000001, 32'h007fffff};

    reset = 1'b1; valid = 1'b0; din1 = '0; din2 = '0;
    repeat (3) @(negedge clk);
    compared++;
    if (result !== 32'h0 || ready !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_state result=%h ready=%b want 0/0", result, ready);
    end
    reset = 1'b0;

    for (int i = 0; i < 17; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].e, i);

    // extra starts while busy must be dropped: exactly one ready
    base = ready_cnt;
    @(negedge clk);
    din1 = 32'h40000000; din2 = 32'h40400000; valid = 1'b1;
    exp_q.push_back(32'h40a00000); id_q.push_back(100);
    @(negedge clk); valid = 1'b0;
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk);
      valid = (k % 2 == 0);
      din1 = 32'h3f800000; din2 = 32'h3f800000;
    end
    @(negedge clk); valid = 1'b0;
    repeat (14) @(negedge clk);
    compared++;
    if (ready_cnt - base != 1) begin
      mismatched++;
      $display("FAIL busy_ignore ready pulses got=%0d want=1", ready_cnt - base);
    end

    // reset two cycles after UNPACK aborts the op and clears result at once
    run_op(32'h3f800000, 32'h3f800000, 32'h40000000, 200);
    base = ready_cnt;
    @(negedge clk);
    din1 = 32'h40000000; din2 = 32'h40400000; valid = 1'b1;
    @(negedge clk); valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    compared++;
    if (result !== 32'h0 || ready !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_abort result=%h ready=%b want 0/0", result, ready);
    end
    @(negedge clk); reset = 1'b0;
    repeat (12) @(negedge clk);
    compared++;
    if (ready_cnt != base) begin
      mismatched++;
      $display("FAIL reset_abort ready pulses got=%0d want=0", ready_cnt - base);
    end

    // block recovers cleanly after the abort
    run_op(32'h40000000, 32'h40400000, 32'h40a00000, 300);

    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain outstanding=%0d want=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
